seg_serial_driver: RTL and testbench
====================================

SEG_SERIAL_DRIVER -- requirements
Module: seg_serial_driver

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2, which is the serial half-period in clk cycles (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: one-cycle request to send a frame.
REQ-005 The block SHALL have port data, input, 32 bits: 8 hex digits; digit7=data[31:28] through digit0=data[3:0].
REQ-006 The block SHALL have port dp, input, 8 bits: decimal point per digit, 1=lit.
REQ-007 The block SHALL have port blank, input, 8 bits: digit blanking, 1=all segments off.
REQ-008 The block SHALL have port SEGLED_CLK, output, 1 bit: serial shift clock.
REQ-009 The block SHALL have port SEGLED_DO, output, 1 bit: serial data.
REQ-010 The block SHALL have port SEGLED_PEN, output, 1 bit: latch/parallel-enable strobe.
REQ-011 The block SHALL have port SEGLED_CLR, output, 1 bit: active-low chain clear.
REQ-012 The block SHALL have port busy, output, 1 bit: frame in progress.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle frame-complete pulse.

Function
REQ-014 The block SHALL encode each digit into a byte {dp,g,f,e,d,c,b,a} with all bits active-low, so "0"=0xC0, "1"=0xF9, "2"=0xA4, "3"=0xB0, "4"=0x99, "5"=0x92, "6"=0x82, "7"=0xF8, "8"=0x80, "9"=0x90, "A"=0x88, "b"=0x83, "C"=0xC6, "d"=0xA1, "E"=0x86, "F"=0x8E.
REQ-015 When dp[i]=1 the block SHALL clear bit7 of digit i's byte; when blank[i]=1 the byte SHALL be 0xFF regardless of dp[i].
REQ-016 Each frame SHALL be 64 bits sent digit7 first, MSB (bit7) first within each byte.
REQ-017 The state machine SHALL have states IDLE, SHIFT_LO, SHIFT_HI and LATCH.
REQ-018 In IDLE, start=1 SHALL capture the encoded frame into the shift register and enter SHIFT_LO on the next cycle, with busy=1, SEGLED_CLK=0 and SEGLED_DO=frame bit 63.
REQ-019 SHIFT_LO SHALL last CLK_DIV cycles with SEGLED_CLK=0 and SEGLED_DO stable, then go to SHIFT_HI.
REQ-020 SHIFT_HI SHALL last CLK_DIV cycles with SEGLED_CLK=1 and SEGLED_DO unchanged, so the receiver samples on the SEGLED_CLK rising edge.
REQ-021 On leaving SHIFT_HI the block SHALL shift out the next bit and return to SHIFT_LO while fewer than 64 bits have been sent; after bit 64 it SHALL enter LATCH.
REQ-022 LATCH SHALL hold SEGLED_PEN=1, SEGLED_CLK=0 and SEGLED_DO=0 for 2*CLK_DIV cycles, then return to IDLE.
REQ-023 On the first IDLE cycle after LATCH the block SHALL assert done=1 for exactly one cycle with busy=0.
REQ-024 busy SHALL be high for exactly 130*CLK_DIV cycles per frame.
REQ-025 start asserted while busy SHALL set a pending flag and overwrite a shadow copy of the encoded frame, so the latest request wins.
REQ-026 If the pending flag is set when LATCH ends, the block SHALL assert done and start the shadow frame in the same cycle (SHIFT_LO next), keeping busy=1 without a gap.
REQ-027 start in the same cycle as done SHALL be accepted like a start in IDLE.
REQ-028 In IDLE, SEGLED_CLK, SEGLED_DO and SEGLED_PEN SHALL be 0, and changes on data, dp or blank SHALL have no effect.
REQ-029 SEGLED_CLR SHALL be 1 at all times except during reset.

Reset
REQ-030 While RST=1 at a clk edge, the block SHALL reset state to IDLE, set busy=0, done=0, SEGLED_CLK=0, SEGLED_DO=0, SEGLED_PEN=0 and SEGLED_CLR=0, and clear the pending flag and counters.
REQ-031 RST asserted mid-frame SHALL abort the frame with no LATCH pulse and no done; SEGLED_CLR SHALL return to 1 the cycle after RST drops.

Structure
REQ-032 State encoding, the frame width (64) and the seven-segment code table constants SHALL live in the shared package seg_pkg.
REQ-033 The hex-to-segment encoder SHALL be the combinational sub-module hex_to_seg, instantiated 8 times.
REQ-034 All outputs SHALL be driven directly from registers.

Verification
REQ-035 With CLK_DIV=2, data=0x01234567, dp=0 and blank=0, a start pulse SHALL produce 64 bits sampled on SEGLED_CLK rising edges equal to C0 F9 A4 B0 99 92 82 F8, busy=1 for 260 cycles, SEGLED_PEN=1 for 4 cycles, and one done pulse.
REQ-036 With data=0x89ABCDEF, dp=0x81 and blank=0x02, the bytes SHALL be 0x00 90 88 83 C6 A1 FF 0E.
REQ-037 A second start at cycle 50 of a frame with data=0xFFFFFFFF SHALL make the next frame follow back-to-back as 8×0x8E with no busy gap and two done pulses in total.
REQ-038 RST asserted at cycle 100 of a frame SHALL force all outputs to their reset values next cycle with no PEN pulse and no done; a new start afterwards SHALL send a full, correct frame.
REQ-039 With CLK_DIV=1, busy SHALL last 130 cycles and SEGLED_CLK SHALL toggle every cycle during shifting.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the serial seven-segment driver.
//   FRAME_W   : bits per frame (8 digits x 8 segment bits)
//   state_e   : driver state machine encoding
//   SEG_TABLE : active-low {dp,g,f,e,d,c,b,a} codes indexed by hex value;
//               bit7 (dp) is 1 (off) in every entry.
package seg_pkg;
  localparam int FRAME_W = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_e;

  // Entry 15 first, entry 0 last.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex digit to active-low seven-segment byte.
//   hex   : digit value 0..F
//   dp    : 1 = decimal point lit
//   blank : 1 = all segments off (overrides dp)
//   seg   : {dp,g,f,e,d,c,b,a}, active low
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);
  always_comb begin
    seg    = SEG_TABLE[hex];
    seg[7] = ~dp;
    if (blank) seg = 8'hFF;
  end
endmodule

// File: rtl/seg_serial_driver.sv
// Serial driver for an 8-digit shift-register seven-segment display chain.
// A start request encodes data/dp/blank into a 64-bit frame which is shifted
// out MSB first (digit7 first); the receiver samples SEGLED_DO on the rising
// edge of SEGLED_CLK, then SEGLED_PEN latches the chain.
//   clk, RST         : system clock, synchronous active-high reset
//   start            : one-cycle frame request (queued if busy, latest wins)
//   data, dp, blank  : 8 hex digits, per-digit decimal point and blanking
//   SEGLED_CLK/DO    : serial clock / data
//   SEGLED_PEN       : latch strobe
//   SEGLED_CLR       : active-low chain clear, low only while in reset
//   busy, done       : frame in progress / one-cycle completion pulse
module seg_serial_driver
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        start,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  input  logic [7:0]  blank,
  output logic        SEGLED_CLK,
  output logic        SEGLED_DO,
  output logic        SEGLED_PEN,
  output logic        SEGLED_CLR,
  output logic        busy,
  output logic        done
);
  localparam logic [8:0] DIV_M1 = 9'(CLK_DIV - 1);
  localparam logic [8:0] LAT_M1 = 9'(2 * CLK_DIV - 1);

  logic [7:0][7:0]      enc;
  logic [FRAME_W-1:0]   frame;

  for (genvar g = 0; g < 8; g++) begin : g_enc
    hex_to_seg u_enc (
      .hex   (data[4*g +: 4]),
      .dp    (dp[g]),
      .blank (blank[g]),
      .seg   (enc[g])
    );
  end
  assign frame = enc;

  state_e             state_q, state_d;
  logic [8:0]         cnt_q, cnt_d;
  logic [5:0]         bit_q, bit_d;
  logic [FRAME_W-1:0] sr_q, sr_d, shadow_q, shadow_d;
  logic               pend_q, pend_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               sclk_q, sclk_d, sdo_q, sdo_d, pen_q, pen_d, clr_q, clr_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 9'd1;
    bit_d    = bit_q;
    sr_d     = sr_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    done_d   = 1'b0;
    clr_d    = 1'b1;

    // Requests during a frame are parked; a newer one replaces the older.
    if (start && state_q != IDLE) begin
      pend_d   = 1'b1;
      shadow_d = frame;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          sr_d    = frame;
          bit_d   = '0;
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (cnt_q == DIV_M1) begin
          cnt_d   = '0;
          state_d = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (cnt_q == DIV_M1) begin
          cnt_d = '0;
          if (bit_q == 6'd63) begin
            state_d = LATCH;
          end else begin
            bit_d   = bit_q + 6'd1;
            sr_d    = {sr_q[FRAME_W-2:0], 1'b0};
            state_d = SHIFT_LO;
          end
        end
      end
      LATCH: begin
        if (cnt_q == LAT_M1) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
          // Chain straight into a queued frame; a start in this very
          // cycle is newer than the shadow copy.
          if (start || pend_q) begin
            sr_d    = start ? frame : shadow_q;
            bit_d   = '0;
            pend_d  = 1'b0;
            state_d = SHIFT_LO;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of what the next state implies.
    busy_d = (state_d != IDLE);
    sclk_d = (state_d == SHIFT_HI);
    pen_d  = (state_d == LATCH);
    sdo_d  = (state_d == SHIFT_LO || state_d == SHIFT_HI) ? sr_d[FRAME_W-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sr_q     <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      sdo_q    <= 1'b0;
      pen_q    <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sr_q     <= sr_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      sdo_q    <= sdo_d;
      pen_q    <= pen_d;
      clr_q    <= clr_d;
    end
  end

  assign SEGLED_CLK = sclk_q;
  assign SEGLED_DO  = sdo_q;
  assign SEGLED_PEN = pen_q;
  assign SEGLED_CLR = clr_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_seg_serial_driver.sv
// Directed bench for seg_serial_driver: one instance at CLK_DIV=2 and one at
// CLK_DIV=1, a negedge monitor that collects serial bits and cycle counts.
module tb_seg_serial_driver;
  logic        clk = 1'b0, RST = 1'b1, start = 1'b0, start1 = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  dp = '0, blank = '0;
  logic        sclk, sdo, pen, clr, busy, done;
  logic        sclk1, sdo1, pen1, clr1, busy1, done1;

  int errs = 0, checks = 0;

  localparam logic [63:0] F0 = 64'hC0F9A4B0999282F8;
  localparam logic [63:0] F1 = 64'h00908883C6A1FF0E;
  localparam logic [63:0] F2 = 64'h8E8E8E8E8E8E8E8E;

  always #5 clk = ~clk;

  seg_serial_driver #(.CLK_DIV(2)) dut (
    .clk(clk), .RST(RST), .start(start), .data(data), .dp(dp), .blank(blank),
    .SEGLED_CLK(sclk), .SEGLED_DO(sdo), .SEGLED_PEN(pen), .SEGLED_CLR(clr),
    .busy(busy), .done(done)
  );

  seg_serial_driver #(.CLK_DIV(1)) dut1 (
    .clk(clk), .RST(RST), .start(start1), .data(data), .dp(dp), .blank(blank),
    .SEGLED_CLK(sclk1), .SEGLED_DO(sdo1), .SEGLED_PEN(pen1), .SEGLED_CLR(clr1),
    .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Monitor
  logic         mon_clr = 1'b0;
  logic [127:0] cap = '0, cap1 = '0;
  int nbits = 0, busy_n = 0, pen_n = 0, done_n = 0, fall_n = 0;
  int busy1_n = 0, tog1_n = 0, shift1_n = 0, done1_n = 0;
  logic sclk_p = 1'b0, busy_p = 1'b0, sclk1_p = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      cap = '0; cap1 = '0; nbits = 0; busy_n = 0; pen_n = 0; done_n = 0; fall_n = 0;
      busy1_n = 0; tog1_n = 0; shift1_n = 0; done1_n = 0;
    end else begin
      if (sclk && !sclk_p) begin cap = {cap[126:0], sdo}; nbits++; end
      if (busy) busy_n++;
      if (pen) pen_n++;
      if (done) done_n++;
      if (busy_p && !busy) fall_n++;
      if (sclk1 && !sclk1_p) cap1 = {cap1[126:0], sdo1};
      if (busy1) busy1_n++;
      if (busy1 && !pen1) begin
        shift1_n++;
        if (sclk1 != sclk1_p) tog1_n++;
      end
      if (done1) done1_n++;
    end
    sclk_p = sclk; busy_p = busy; sclk1_p = sclk1;
  end

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(negedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic pulse(input bit which);
    @(posedge clk); #1;
    if (which) start1 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start1 = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    k = 0;
    while (done_n < n && k < budget) begin @(negedge clk); #1; k++; end
    chk("done_wait", done_n, n);
    repeat (6) @(posedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {busy, done, sclk, sdo, pen}, 5'b0);
    chk("rst_clr", clr, 1'b0);
    @(posedge clk); #1 RST = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("clr_after_rst", clr, 1'b1);

    // Basic frame, CLK_DIV=2
    data = 32'h01234567;
    clr_mon();
    pulse(1'b0);
    @(negedge clk);
    chk("first_cycle", {busy, sclk, sdo}, 3'b101);
    wait_done(1, 1000);
    chk("f0_bits", cap[63:0], F0);
    chk("f0_nbits", nbits, 64);
    chk("f0_busy", busy_n, 260);
    chk("f0_pen", pen_n, 4);
    chk("f0_done", done_n, 1);

    // Idle: input changes do nothing
    clr_mon();
    data = 32'hDEADBEEF; @(posedge clk); #1;
    dp = 8'hFF; @(posedge clk); #1;
    blank = 8'h55; repeat (10) @(posedge clk);
    @(negedge clk);
    chk("idle_outs", {busy, sclk, sdo, pen}, 4'b0);
    chk("idle_bits", nbits, 0);
    chk("idle_busy", busy_n, 0);

    // dp / blank
    data = 32'h89ABCDEF; dp = 8'h81; blank = 8'h02;
    clr_mon();
    pulse(1'b0);
    wait_done(1, 1000);
    chk("f1_bits", cap[63:0], F1);
    chk("f1_busy", busy_n, 260);

    // Queued request, back-to-back
    data = 32'h01234567; dp = '0; blank = '0;
    clr_mon();
    pulse(1'b0);
    repeat (48) @(posedge clk); #1;
    data = 32'hFFFFFFFF;
    pulse(1'b0);
    wait_done(2, 1500);
    chk("b2b_bits", cap, {F0, F2});
    chk("b2b_nbits", nbits, 128);
    chk("b2b_busy", busy_n, 520);
    chk("b2b_falls", fall_n, 1);
    chk("b2b_pen", pen_n, 8);

    // Mid-frame reset
    data = 32'h01234567;
    clr_mon();
    pulse(1'b0);
    repeat (98) @(posedge clk); #1;
    RST = 1'b1;
    @(posedge clk); #1 RST = 1'b0;
    @(negedge clk);
    chk("abort_outs", {busy, done, sclk, sdo, pen, clr}, 6'b0);
    @(negedge clk);
    chk("abort_clr", clr, 1'b1);
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("abort_pen", pen_n, 0);
    chk("abort_done", done_n, 0);
    clr_mon();
    pulse(1'b0);
    wait_done(1, 1000);
    chk("rerun_bits", cap[63:0], F0);
    chk("rerun_busy", busy_n, 260);

    // CLK_DIV=1 instance
    clr_mon();
    pulse(1'b1);
    begin
      int k;
      k = 0;
      while (done1_n < 1 && k < 500) begin @(negedge clk); #1; k++; end
    end
    chk("d1_done", done1_n, 1);
    chk("d1_busy", busy1_n, 130);
    chk("d1_shift", shift1_n, 128);
    chk("d1_toggles", tog1_n, 127);
    chk("d1_bits", cap1[63:0], F0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
